// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared rename-stage types and sizing for the physical register file
package free_list_pkg;

    localparam int N_PHYS_REG    = 64;
    localparam int N_ARCH_REG    = 32;
    localparam int PHYS_REG_BITS = $clog2(N_PHYS_REG);
    localparam int N_FREE_REGS   = N_PHYS_REG - N_ARCH_REG;

    typedef struct packed {
        logic [PHYS_REG_BITS-1:0] phys_reg;
        logic                     valid;
        logic                     ready;
    } TAG;

endpackage

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - allocate/retire/flush signals between rename/ROB and the free list
interface free_list_if
    import free_list_pkg::*;
#(
    parameter int N_FREE = N_FREE_REGS
) ();

    logic                      alloc_en;
    TAG                        alloc_tag;
    logic                      retire_en;
    TAG                        free_tag;
    logic                      flush;
    logic [$clog2(N_FREE):0]   free_count;
    logic                      empty;

    modport master (
        output alloc_en, retire_en, free_tag, flush,
        input  alloc_tag, free_count, empty
    );

    modport slave (
        input  alloc_en, retire_en, free_tag, flush,
        output alloc_tag, free_count, empty
    );

endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular physical-tag free list with speculative head restored on flush
module free_list
    import free_list_pkg::*;
#(
    parameter int N_FREE = N_FREE_REGS
) (
    input  logic        clock,
    input  logic        reset,
    free_list_if.slave  bus
);

  localparam int IDX_BITS = $clog2(N_FREE);
  localparam int PTR_BITS = IDX_BITS + 1;

  logic [PHYS_REG_BITS-1:0] list [N_FREE];
  logic [PTR_BITS-1:0]      spec_head;
  logic [PTR_BITS-1:0]      retire_head;
  logic [PTR_BITS-1:0]      tail;
  logic [PTR_BITS-1:0]      retire_head_next;
  logic [PTR_BITS-1:0]      in_flight;
  logic                     do_alloc;
  logic                     do_free;

  // Outputs depend on registered state only; no input reaches them combinationally.
  assign bus.free_count = tail - spec_head;
  assign bus.empty      = (bus.free_count == '0);
  assign bus.alloc_tag  = '{phys_reg: list[spec_head[IDX_BITS-1:0]],
                            valid:    !bus.empty,
                            ready:    1'b0};

  assign do_alloc         = bus.alloc_en && !bus.empty && !bus.flush;
  assign do_free          = bus.retire_en && bus.free_tag.valid;
  assign retire_head_next = retire_head + PTR_BITS'(bus.retire_en);
  assign in_flight        = spec_head - retire_head;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_FREE; i++) begin
        list[i] <= PHYS_REG_BITS'(N_ARCH_REG + i);
      end
      spec_head   <= '0;
      retire_head <= '0;
      tail        <= PTR_BITS'(N_FREE);
    end else begin
      if (do_free) begin
        list[tail[IDX_BITS-1:0]] <= bus.free_tag.phys_reg;
        tail                     <= tail + 1'b1;
      end
      retire_head <= retire_head_next;
      // A same-cycle retire is already folded into the restored head.
      spec_head   <= bus.flush ? retire_head_next
                               : spec_head + PTR_BITS'(do_alloc);
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      bus.free_count <= PTR_BITS'(N_FREE));

  a_retire_behind_alloc: assert property (@(posedge clock) disable iff (reset)
      in_flight <= PTR_BITS'(N_FREE));

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list with directed, hand-computed vectors
module tb_free_list;
  import free_list_pkg::*;

  typedef struct {
    string name;
    int    cnt;
    bit    vld;
    int    tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_miss = 0;

  free_list_if #(.N_FREE(32)) bus ();

  free_list #(.N_FREE(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input string what, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s.%s: got %0d, required %0d", name, what, act, req);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue what the outputs must show after the next rising edge.
  task automatic step(input string name, input bit rst, input bit a, input bit r,
                      input int ftag, input bit fv, input bit fl,
                      input int ecnt, input bit evld, input int etag);
    exp_t e;
    @(negedge clock);
    reset         = rst;
    bus.alloc_en  = a;
    bus.retire_en = r;
    bus.free_tag  = '{phys_reg: PHYS_REG_BITS'(ftag), valid: fv, ready: 1'b0};
    bus.flush     = fl;
    e.name = name; e.cnt = ecnt; e.vld = evld; e.tag = etag;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "free_count", int'(bus.free_count), e.cnt);
        chk(e.name, "valid", int'(bus.alloc_tag.valid), int'(e.vld));
        chk(e.name, "empty", int'(bus.empty), int'(e.cnt == 0));
        chk(e.name, "ready", int'(bus.alloc_tag.ready), 0);
        if (e.vld) chk(e.name, "phys_reg", int'(bus.alloc_tag.phys_reg), e.tag);
      end
    end
  end

  initial begin : stimulus
    reset         = 1'b1;
    bus.alloc_en  = 1'b0;
    bus.retire_en = 1'b0;
    bus.free_tag  = '0;
    bus.flush     = 1'b0;

    // Reset state, then drain all 32 reset tags in order.
    step("reset", 1, 0, 0, 0, 0, 0, 32, 1, 32);
    for (int i = 0; i < 32; i++)
      step("drain", 0, 1, 0, 0, 0, 0, 31 - i, i < 31, 33 + i);

    // Free into an empty list with a simultaneous alloc: alloc must be dropped.
    step("empty_free", 0, 1, 1, 5, 1, 0, 1, 1, 5);

    // Steady state: alloc and free together keep the count at 32.
    step("reset2", 1, 0, 0, 0, 0, 0, 32, 1, 32);
    for (int i = 0; i < 10; i++)
      step("steady", 0, 1, 1, i, 1, 0, 32, 1, 33 + i);
    for (int i = 0; i < 22; i++)
      step("steady_drain", 0, 1, 0, 0, 0, 0, 31 - i, 1, (i < 21) ? 43 + i : 0);
    for (int i = 0; i < 10; i++)
      step("freed_tags", 0, 1, 0, 0, 0, 0, 9 - i, i < 9, i + 1);

    // Flush after two retires without a destination register.
    step("reset3", 1, 0, 0, 0, 0, 0, 32, 1, 32);
    for (int i = 0; i < 6; i++)
      step("fl_alloc", 0, 1, 0, 0, 0, 0, 31 - i, 1, 33 + i);
    step("fl_retire", 0, 0, 1, 0, 0, 0, 26, 1, 38);
    step("fl_retire", 0, 0, 1, 0, 0, 0, 26, 1, 38);
    step("flush", 0, 0, 0, 0, 0, 1, 30, 1, 34);

    // Flush in the same cycle as the second retire, with alloc_en also raised.
    step("reset4", 1, 0, 0, 0, 0, 0, 32, 1, 32);
    for (int i = 0; i < 6; i++)
      step("fl2_alloc", 0, 1, 0, 0, 0, 0, 31 - i, 1, 33 + i);
    step("fl2_retire", 0, 0, 1, 0, 0, 0, 26, 1, 38);
    step("flush_retire", 0, 1, 1, 0, 0, 1, 30, 1, 34);

    // Reset mid-stream with every other control input active.
    for (int i = 0; i < 3; i++)
      step("pre_reset", 0, 1, 0, 0, 0, 0, 29 - i, 1, 35 + i);
    step("mid_reset", 1, 1, 1, 7, 1, 1, 32, 1, 32);
    step("post_reset", 0, 1, 0, 0, 0, 0, 31, 1, 33);

    @(negedge clock);
    bus.alloc_en  = 1'b0;
    bus.retire_en = 1'b0;
    bus.flush     = 1'b0;

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_miss++;
      $display("FAIL drain_queue: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
